// File: rtl/calc_key_sequencer_if.sv
// calc_key_sequencer_if
//   Bundles the key strobe from the cursor keypad and the start/done
//   handshake to the external ALU.
//
//   Handshake semantics:
//     key_valid  : one-cycle strobe; key_code is valid in that cycle only.
//                  The sequencer has no backpressure, so a key is either
//                  consumed, queued, or dropped in the cycle it arrives.
//     alu_start  : one-cycle pulse from the sequencer; alu_a/alu_b/alu_op
//                  are valid from that cycle until alu_done is seen.
//     alu_done   : one-cycle pulse from the ALU; alu_result is valid in
//                  that cycle only.
//
//   Modports:
//     master : the sequencer (receives keys, drives the ALU request)
//     slave  : the environment (keypad + ALU)
interface calc_key_sequencer_if #(
  parameter int W = 16
);
  logic         key_valid;
  logic [4:0]   key_code;
  logic         alu_start;
  logic [2:0]   alu_op;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic         alu_done;
  logic [W-1:0] alu_result;

  modport master (
    input  key_valid, key_code, alu_done, alu_result,
    output alu_start, alu_op, alu_a, alu_b
  );

  modport slave (
    output key_valid, key_code, alu_done, alu_result,
    input  alu_start, alu_op, alu_a, alu_b
  );
endinterface

// File: rtl/calc_key_sequencer.sv
// calc_key_sequencer
//   Controller between the grid cursor keypad and the calculator ALU.
//   Builds operands A and B from hex digit keys, latches the operator,
//   launches the external ALU on EXE and presents the result.
//
//   Ports:
//     clk, rst     : clock, synchronous active-high reset
//     bus          : calc_key_sequencer_if.master (keys in, ALU handshake)
//     oct_mode     : restrict digit keys to 0-7
//     restriction  : registered copy of oct_mode, to the cursor
//     disp_val     : value to display (combinational from registers)
//     state        : FSM state, 0 S_A, 1 S_B, 2 S_EXEC, 3 S_RES
//     error        : sticky ALU timeout flag, cleared by reset or CLR
//
//   Parameters: NDIG digits per operand (W = 4*NDIG), TIMEOUT cycles to
//   wait for alu_done.
//
//   Optional macro CALC_KEY_FIFO_EN: adds a 2-entry key FIFO so keys
//   pressed while the ALU is busy are queued instead of dropped.
module calc_key_sequencer #(
  parameter int NDIG    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  calc_key_sequencer_if.master  bus,
  input  logic                  oct_mode,
  output logic                  restriction,
  output logic [4*NDIG-1:0]     disp_val,
  output logic [1:0]            state,
  output logic                  error
);
  localparam int W  = 4 * NDIG;
  localparam int CW = $clog2(NDIG + 1);
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_A    = 2'd0,
    S_B    = 2'd1,
    S_EXEC = 2'd2,
    S_RES  = 2'd3
  } state_t;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_MULT = 3'd2;
  localparam logic [2:0] OP_AND  = 3'd3;
  localparam logic [2:0] OP_OR   = 3'd4;

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  r_q, r_d;
  logic [2:0]    op_q, op_d;
  logic [CW-1:0] cnt_a_q, cnt_a_d;
  logic [CW-1:0] cnt_b_q, cnt_b_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          alu_start_q, alu_start_d;
  logic          error_q, error_d;
  logic          restriction_q, restriction_d;

  // Key presented to the FSM this cycle
  logic          k_valid;
  logic [4:0]    k_code;

`ifdef CALC_KEY_FIFO_EN
  // Two-entry FIFO. The FSM pops one key per cycle outside S_EXEC;
  // a key arriving while full is dropped (fullness checked before pop).
  logic [4:0] fifo_mem_q [2];
  logic [4:0] fifo_mem_d [2];
  logic       fifo_wr_q, fifo_wr_d;
  logic       fifo_rd_q, fifo_rd_d;
  logic [1:0] fifo_cnt_q, fifo_cnt_d;
  logic       fifo_push, fifo_pop;

  always_comb begin
    fifo_push  = bus.key_valid && (fifo_cnt_q != 2'd2);
    fifo_pop   = (fifo_cnt_q != 2'd0) && (state_q != S_EXEC);
    fifo_mem_d = fifo_mem_q;
    fifo_wr_d  = fifo_wr_q;
    fifo_rd_d  = fifo_rd_q;
    if (fifo_push) begin
      fifo_mem_d[fifo_wr_q] = bus.key_code;
      fifo_wr_d             = ~fifo_wr_q;
    end
    if (fifo_pop) begin
      fifo_rd_d = ~fifo_rd_q;
    end
    fifo_cnt_d = fifo_cnt_q + {1'b0, fifo_push} - {1'b0, fifo_pop};
    k_valid    = fifo_pop;
    k_code     = fifo_mem_q[fifo_rd_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_mem_q[0] <= 5'd0;
      fifo_mem_q[1] <= 5'd0;
      fifo_wr_q     <= 1'b0;
      fifo_rd_q     <= 1'b0;
      fifo_cnt_q    <= 2'd0;
    end else begin
      fifo_mem_q <= fifo_mem_d;
      fifo_wr_q  <= fifo_wr_d;
      fifo_rd_q  <= fifo_rd_d;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end
`else
  // Keys go straight to the FSM; S_EXEC simply never looks at them.
  always_comb begin
    k_valid = bus.key_valid;
    k_code  = bus.key_code;
  end
`endif

  // Key decode
  logic       k_digit, k_op, k_exe, k_ce, k_clr;
  logic [2:0] k_op_code;

  always_comb begin
    // Digits 8-F vanish completely in octal mode (not even counted)
    k_digit   = k_valid && !k_code[4] && !(oct_mode && k_code[3]);
    k_exe     = k_valid && (k_code == 5'h13);
    k_ce      = k_valid && (k_code == 5'h16);
    k_clr     = k_valid && (k_code == 5'h17);
    k_op      = 1'b0;
    k_op_code = OP_ADD;
    if (k_valid) begin
      case (k_code)
        5'h10: begin k_op = 1'b1; k_op_code = OP_ADD;  end
        5'h11: begin k_op = 1'b1; k_op_code = OP_MULT; end
        5'h12: begin k_op = 1'b1; k_op_code = OP_AND;  end
        5'h14: begin k_op = 1'b1; k_op_code = OP_SUB;  end
        5'h15: begin k_op = 1'b1; k_op_code = OP_OR;   end
        default: ;
      endcase
    end
  end

  // Next-state logic
  always_comb begin
    state_d       = state_q;
    a_d           = a_q;
    b_d           = b_q;
    r_d           = r_q;
    op_d          = op_q;
    cnt_a_d       = cnt_a_q;
    cnt_b_d       = cnt_b_q;
    tmo_d         = tmo_q;
    alu_start_d   = 1'b0;
    error_d       = error_q;
    restriction_d = oct_mode;

    if (k_clr && (state_q != S_EXEC)) begin
      state_d       = S_A;
      a_d           = '0;
      b_d           = '0;
      r_d           = '0;
      op_d          = OP_ADD;
      cnt_a_d       = '0;
      cnt_b_d       = '0;
      tmo_d         = '0;
      error_d       = 1'b0;
      restriction_d = 1'b0;
    end else begin
      case (state_q)
        S_A: begin
          if (k_digit && (cnt_a_q < CW'(NDIG))) begin
            a_d     = {a_q[W-5:0], k_code[3:0]};
            cnt_a_d = cnt_a_q + 1'b1;
          end else if (k_op) begin
            op_d    = k_op_code;
            b_d     = '0;
            cnt_b_d = '0;
            state_d = S_B;
          end else if (k_ce) begin
            a_d     = '0;
            cnt_a_d = '0;
          end
        end

        S_B: begin
          if (k_digit && (cnt_b_q < CW'(NDIG))) begin
            b_d     = {b_q[W-5:0], k_code[3:0]};
            cnt_b_d = cnt_b_q + 1'b1;
          end else if (k_op) begin
            op_d = k_op_code;
          end else if (k_exe) begin
            state_d     = S_EXEC;
            alu_start_d = 1'b1;
            tmo_d       = '0;
          end else if (k_ce) begin
            b_d     = '0;
            cnt_b_d = '0;
          end
        end

        S_EXEC: begin
          // alu_done is tested first so a done coinciding with the last
          // timeout cycle still completes normally.
          if (bus.alu_done) begin
            r_d     = bus.alu_result;
            a_d     = bus.alu_result;
            cnt_a_d = CW'(NDIG);
            state_d = S_RES;
          end else if (tmo_q == TW'(TIMEOUT - 1)) begin
            state_d = S_A;
            a_d     = '0;
            b_d     = '0;
            r_d     = '0;
            op_d    = OP_ADD;
            cnt_a_d = '0;
            cnt_b_d = '0;
            tmo_d   = '0;
            error_d = 1'b1;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end

        S_RES: begin
          if (k_digit) begin
            a_d     = {{(W-4){1'b0}}, k_code[3:0]};
            cnt_a_d = CW'(1);
            state_d = S_A;
          end else if (k_op) begin
            // Chaining: the result already sits in A
            op_d    = k_op_code;
            b_d     = '0;
            cnt_b_d = '0;
            state_d = S_B;
          end else if (k_exe) begin
            a_d         = r_q;
            state_d     = S_EXEC;
            alu_start_d = 1'b1;
            tmo_d       = '0;
          end else if (k_ce) begin
            a_d     = '0;
            b_d     = '0;
            r_d     = '0;
            cnt_a_d = '0;
            cnt_b_d = '0;
            state_d = S_A;
          end
        end

        default: state_d = S_A;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_A;
      a_q           <= '0;
      b_q           <= '0;
      r_q           <= '0;
      op_q          <= OP_ADD;
      cnt_a_q       <= '0;
      cnt_b_q       <= '0;
      tmo_q         <= '0;
      alu_start_q   <= 1'b0;
      error_q       <= 1'b0;
      restriction_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      a_q           <= a_d;
      b_q           <= b_d;
      r_q           <= r_d;
      op_q          <= op_d;
      cnt_a_q       <= cnt_a_d;
      cnt_b_q       <= cnt_b_d;
      tmo_q         <= tmo_d;
      alu_start_q   <= alu_start_d;
      error_q       <= error_d;
      restriction_q <= restriction_d;
    end
  end

  always_comb begin
    case (state_q)
      S_A:     disp_val = a_q;
      S_B:     disp_val = (cnt_b_q != '0) ? b_q : a_q;
      S_EXEC:  disp_val = b_q;
      S_RES:   disp_val = r_q;
      default: disp_val = a_q;
    endcase
  end

  assign bus.alu_start = alu_start_q;
  assign bus.alu_op    = op_q;
  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;
  assign restriction   = restriction_q;
  assign state         = state_q;
  assign error         = error_q;
endmodule

// File: tb/tb_calc_key_sequencer.sv
// tb_calc_key_sequencer
//   Directed bench for calc_key_sequencer (NDIG=4, TIMEOUT=64).
//   Inputs are driven and outputs sampled on the falling clock edge.
module tb_calc_key_sequencer;
  localparam int W = 16;

  localparam logic [4:0] K_ADD = 5'h10;
  localparam logic [4:0] K_EXE = 5'h13;
  localparam logic [4:0] K_SUB = 5'h14;
  localparam logic [4:0] K_CE  = 5'h16;
  localparam logic [4:0] K_CLR = 5'h17;

  logic         clk;
  logic         rst;
  logic         oct_mode;
  logic         restriction;
  logic [W-1:0] disp_val;
  logic [1:0]   state;
  logic         error;

  int checks;
  int fails;
  int start_cnt;

  calc_key_sequencer_if #(.W(W)) bus ();

  calc_key_sequencer #(.NDIG(4), .TIMEOUT(64)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .oct_mode    (oct_mode),
    .restriction (restriction),
    .disp_val    (disp_val),
    .state       (state),
    .error       (error)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  // Counts alu_start cycles
  initial start_cnt = 0;
  always @(posedge clk) if (!rst && bus.alu_start) start_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One key strobe; returns on the falling edge where its effect is visible.
  task automatic press(input logic [4:0] code);
    @(negedge clk);
    bus.key_valid = 1'b1;
    bus.key_code  = code;
    @(negedge clk);
    bus.key_valid = 1'b0;
    bus.key_code  = 5'h00;
`ifdef CALC_KEY_FIFO_EN
    @(negedge clk);
`endif
  endtask

  // ALU done pulse 'lat' cycles after the start seen at the current edge.
  task automatic alu_finish(input int lat, input logic [W-1:0] res);
    repeat (lat - 1) @(negedge clk);
    bus.alu_done   = 1'b1;
    bus.alu_result = res;
    @(negedge clk);
    bus.alu_done   = 1'b0;
    bus.alu_result = '0;
  endtask

  initial begin
    checks         = 0;
    fails          = 0;
    rst            = 1'b1;
    oct_mode       = 1'b0;
    bus.key_valid  = 1'b0;
    bus.key_code   = 5'h00;
    bus.alu_done   = 1'b0;
    bus.alu_result = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_disp", 32'(disp_val), 32'h0);
    chk("rst_start", 32'(bus.alu_start), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_restr", 32'(restriction), 32'd0);
    chk("rst_op", 32'(bus.alu_op), 32'd0);

    // 12 + 34 = 0x46, done three cycles after start
    press(5'h1);
    press(5'h2);
    chk("a_12", 32'(disp_val), 32'h0012);
    press(K_ADD);
    chk("add_state", 32'(state), 32'd1);
    chk("add_disp_a", 32'(disp_val), 32'h0012);
    press(5'h3);
    chk("b_3", 32'(disp_val), 32'h0003);
    press(5'h4);
    press(K_EXE);
    chk("exe_state", 32'(state), 32'd2);
    chk("exe_start", 32'(bus.alu_start), 32'd1);
    chk("exe_a", 32'(bus.alu_a), 32'h0012);
    chk("exe_b", 32'(bus.alu_b), 32'h0034);
    chk("exe_op", 32'(bus.alu_op), 32'd0);
    chk("exe_disp", 32'(disp_val), 32'h0034);
    @(negedge clk);
    chk("start_pulse_end", 32'(bus.alu_start), 32'd0);
    alu_finish(2, 16'h0046);
    chk("res_state", 32'(state), 32'd3);
    chk("res_disp", 32'(disp_val), 32'h0046);
    chk("res_start_cnt", 32'(start_cnt), 32'd1);

    // Chaining on the result, then re-run with EXE
    press(K_SUB);
    chk("chain_state", 32'(state), 32'd1);
    chk("chain_disp", 32'(disp_val), 32'h0046);
    press(5'h6);
    press(K_EXE);
    chk("chain_a", 32'(bus.alu_a), 32'h0046);
    chk("chain_b", 32'(bus.alu_b), 32'h0006);
    alu_finish(1, 16'h0040);
    chk("chain_res", 32'(disp_val), 32'h0040);
    press(K_EXE);
    chk("rerun_state", 32'(state), 32'd2);
    chk("rerun_start", 32'(bus.alu_start), 32'd1);
    chk("rerun_a", 32'(bus.alu_a), 32'h0040);
    chk("rerun_b", 32'(bus.alu_b), 32'h0006);
    chk("rerun_op", 32'(bus.alu_op), 32'd1);

    // Key during S_EXEC
    press(5'h5);
    chk("exec_key_state", 32'(state), 32'd2);
    chk("exec_key_a", 32'(bus.alu_a), 32'h0040);
    alu_finish(1, 16'h003A);
    chk("rerun_res", 32'(disp_val), 32'h003A);
    chk("rerun_res_state", 32'(state), 32'd3);
    @(negedge clk);
`ifdef CALC_KEY_FIFO_EN
    chk("fifo_key_state", 32'(state), 32'd0);
    chk("fifo_key_a", 32'(bus.alu_a), 32'h0005);
`else
    chk("drop_key_state", 32'(state), 32'd3);
    chk("drop_key_a", 32'(bus.alu_a), 32'h003A);
`endif
    chk("start_cnt3", 32'(start_cnt), 32'd3);

    // CLR, then digit limit and CE
    press(K_CLR);
    chk("clr_state", 32'(state), 32'd0);
    chk("clr_disp", 32'(disp_val), 32'h0);
    chk("clr_op", 32'(bus.alu_op), 32'd0);
    press(5'h1);
    press(5'h2);
    press(5'h3);
    press(5'h4);
    press(5'h5);
    chk("ndig_limit", 32'(disp_val), 32'h1234);
    press(K_CE);
    chk("ce_disp", 32'(disp_val), 32'h0);

    // Octal mode
    @(negedge clk);
    oct_mode = 1'b1;
    chk("restr_lag", 32'(restriction), 32'd0);
    @(negedge clk);
    chk("restr_on", 32'(restriction), 32'd1);
    press(5'h9);
    chk("oct_9_ignored", 32'(disp_val), 32'h0);
    press(5'h7);
    chk("oct_7", 32'(disp_val), 32'h0007);
    oct_mode = 1'b0;
    press(K_CLR);

    // Timeout: 64 cycles in S_EXEC, then abort
    press(5'h1);
    press(K_SUB);
    press(5'h2);
    press(K_EXE);
    repeat (63) @(negedge clk);
    chk("tmo_last_state", 32'(state), 32'd2);
    chk("tmo_last_err", 32'(error), 32'd0);
    @(negedge clk);
    chk("tmo_err", 32'(error), 32'd1);
    chk("tmo_state", 32'(state), 32'd0);
    chk("tmo_a", 32'(bus.alu_a), 32'h0);
    chk("tmo_b", 32'(bus.alu_b), 32'h0);
    chk("tmo_op", 32'(bus.alu_op), 32'd0);
    press(5'h3);
    chk("err_sticky", 32'(error), 32'd1);
    chk("err_digit", 32'(disp_val), 32'h0003);

    // alu_done outside S_EXEC is ignored
    @(negedge clk);
    bus.alu_done   = 1'b1;
    bus.alu_result = 16'hBEEF;
    @(negedge clk);
    bus.alu_done   = 1'b0;
    bus.alu_result = '0;
    chk("stray_done_state", 32'(state), 32'd0);
    chk("stray_done_disp", 32'(disp_val), 32'h0003);

    press(K_CLR);
    chk("clr_error", 32'(error), 32'd0);

    // alu_done on the final timeout cycle wins
    press(5'h2);
    press(K_ADD);
    press(5'h1);
    press(K_EXE);
    repeat (63) @(negedge clk);
    alu_finish(1, 16'h1111);
    chk("tie_state", 32'(state), 32'd3);
    chk("tie_error", 32'(error), 32'd0);
    chk("tie_disp", 32'(disp_val), 32'h1111);

    // Digit in S_RES starts a fresh A
    press(5'h8);
    chk("res_digit_state", 32'(state), 32'd0);
    chk("res_digit_a", 32'(disp_val), 32'h0008);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule

// File: doc/calc_key_sequencer.md
Name: calc_key_sequencer

Overview:
- Controller between the grid cursor keypad and the calculator ALU.
- Consumes 5-bit key codes (strobed on key press), builds operands A and B from hex digits, and latches the operator.
- On EXE, runs an external ALU over a start/done handshake, then presents the result.
- Drives the cursor's restriction input (octal mode) and the display value.

Parameters:
NDIG, 4, maximum digits per operand (4 bits each); W = 4*NDIG
TIMEOUT, 64, cycles to wait for alu_done before aborting

Ports:
clk  in  1  clock
rst  in  1  reset
key_valid  in  1  one-cycle strobe, key_code valid
key_code  in  5  0x00-0x0F digit; 0x10 add, 0x11 mult, 0x12 and, 0x13 EXE, 0x14 sub, 0x15 or, 0x16 CE, 0x17 CLR; others ignored
oct_mode  in  1  restrict digits to 0-7
restriction  out  1  to cursor; registered copy of oct_mode
alu_start  out  1  one-cycle pulse launching the ALU
alu_op  out  3  0 add, 1 sub, 2 mult, 3 and, 4 or
alu_a  out  W  operand A
alu_b  out  W  operand B
alu_done  in  1  one-cycle pulse, alu_result valid
alu_result  in  W  ALU result
disp_val  out  W  value to display
state  out  2  0 S_A, 1 S_B, 2 S_EXEC, 3 S_RES
error  out  1  sticky timeout flag

Behaviour:
- Reset rst, synchronous, active-high; clock clk.
- Reset values: state=S_A; A=B=R=0; op=add (0); digit counts=0; alu_start=0; error=0; restriction=0.
- Digit entry:
  - Operand <= {operand[W-5:0], digit}; count++.
  - When count==NDIG, further digits are ignored (no wrap, no shift).
  - When oct_mode=1, digits 8-F are ignored entirely.
- S_A:
  - digit → appends to A.
  - operator → op latched, B=0, cntB=0, go S_B.
  - EXE → ignored.
  - CE → A=0, cntA=0.
- S_B:
  - digit → appends to B.
  - operator → replaces op, stays in S_B.
  - EXE → go S_EXEC; alu_start=1 for exactly the first cycle of S_EXEC.
  - CE → B=0, cntB=0.
- S_EXEC:
  - alu_a=A, alu_b=B, alu_op held stable throughout.
  - All keys, including CLR, are dropped.
  - alu_done → R=alu_result, A=alu_result, cntA=NDIG, go S_RES.
  - Timeout counter cleared on entry. If it reaches TIMEOUT-1 without alu_done: error=1, all registers cleared, go S_A.
  - alu_done arriving in the same cycle as the timeout wins; no error.
- S_RES:
  - digit → A=digit, cntA=1, go S_A.
  - operator → op latched, B=0, cntB=0, go S_B (chaining on the result).
  - EXE → re-run with A=R and the same B/op: go S_EXEC, pulse alu_start.
  - CE → A=B=R=0, go S_A.
- CLR in any state except S_EXEC: identical to reset, and also clears error.
- alu_done outside S_EXEC is ignored.
- disp_val is combinational from registers:
  - S_A: A
  - S_B: B if cntB>0, else A
  - S_EXEC: B
  - S_RES: R
- Arithmetic is done by the external ALU; this block does no math beyond the shift-in.

Optional Feature:
CALC_KEY_FIFO_EN
- Defined:
  - 2-entry key FIFO in front of the FSM.
  - Keys arriving during S_EXEC are queued, not dropped.
  - FSM pops one key per cycle when not in S_EXEC.
  - When full, new keys are dropped.
  - CLR pushes like any other key.
  - Reset empties the FIFO.
- Undefined: keys go straight to the FSM; keys in S_EXEC are dropped.

Test Plan:
- Keys 1,2,add,3,4,EXE; ALU returns done 3 cycles after start with 0x0046 → single alu_start, alu_a=0x0012, alu_b=0x0034, alu_op=0, state S_RES, disp_val=0x0046.
- Keys 1,2,3,4,5 → A=0x1234 (fifth digit ignored); CE → A=0, disp_val=0.
- oct_mode=1, keys 9,7 → restriction=1 one cycle later, A=0x0007.
- Start EXE, never assert alu_done → after TIMEOUT cycles error=1, state S_A, A=B=0; CLR → error=0.
- After result 0x0046, keys sub,6,EXE, done with 0x0040, then EXE again → second start has alu_a=0x0040, alu_b=0x0006, alu_op=1.
- Key 5 pressed during S_EXEC → dropped (no A change) without the macro; with CALC_KEY_FIFO_EN it is applied after S_RES, giving A=0x0005, state S_A.
